// File: rtl/ce_gen.sv
// Clock-enable generator: pixel and CPU enable pairs derived from clk_sys, with runtime turbo
// and contention hold. Turbo switches only on the base boundary, so CPU and pixel phases stay aligned.
module ce_gen #(
    parameter int SYS_DIV   = 8,
    parameter int CPU_RATIO = 2,
    parameter int MAX_TURBO = 2
) (
    input  logic       clk_sys,
    input  logic       nRESET,
    input  logic [1:0] turbo,
    input  logic       cpu_hold,
    output logic       ce_pix_p,
    output logic       ce_pix_n,
    output logic       ce_cpu_p,
    output logic       ce_cpu_n,
    output logic [1:0] turbo_act
);

    localparam int BASE = SYS_DIV * CPU_RATIO;
    localparam int PCW  = (SYS_DIV > 1) ? $clog2(SYS_DIV) : 1;
    localparam int PW   = (CPU_RATIO > 1) ? $clog2(CPU_RATIO) : 1;
    localparam int PERW = $clog2(BASE + 1);

    // Largest shift that still leaves a CPU period of at least 2 clk_sys cycles.
    function automatic int max_shift(input int base);
        int s;
        s = 0;
        for (int i = 1; i <= 3; i++) begin
            if ((base >> i) >= 2) s = i;
        end
        return s;
    endfunction

    localparam int SHIFT_CAP = max_shift(BASE);
    localparam int TCAP      = (MAX_TURBO < SHIFT_CAP) ? MAX_TURBO : SHIFT_CAP;

    function automatic logic [1:0] clamp_turbo(input logic [1:0] t);
        if (int'(t) > TCAP) return 2'(TCAP);
        return t;
    endfunction

    logic [PCW-1:0]  pcnt_q, pcnt_d;
    logic [PW-1:0]   pidx_q, pidx_d;
    logic [PERW-1:0] ccnt_q, ccnt_d;
    logic [1:0]      turbo_act_q, turbo_act_d;
    logic            hold_q, hold_d;
    logic            pix_p_q, pix_p_d;
    logic            pix_n_q, pix_n_d;
    logic            cpu_p_q, cpu_p_d;
    logic            cpu_n_q, cpu_n_d;

    logic            pcnt_wrap;
    logic            pidx_last;
    logic            base_b;
    logic            cpu_start;
    logic [PERW-1:0] period;

    always_comb begin
        pcnt_wrap   = (pcnt_q == PCW'(SYS_DIV - 1));
        pidx_last   = (pidx_q == PW'(CPU_RATIO - 1));
        base_b      = pcnt_wrap && pidx_last;
        period      = PERW'(BASE) >> turbo_act_q;
        cpu_start   = (ccnt_q == '0);

        pcnt_d      = pcnt_wrap ? '0 : pcnt_q + PCW'(1);
        pidx_d      = pidx_q;
        if (pcnt_wrap) begin
            pidx_d = pidx_last ? '0 : pidx_q + PW'(1);
        end

        turbo_act_d = base_b ? clamp_turbo(turbo) : turbo_act_q;

        // Forcing ccnt to 0 on the boundary makes the new rate start together with ce_pix_p.
        if (base_b || (ccnt_q == period - PERW'(1))) begin
            ccnt_d = '0;
        end else begin
            ccnt_d = ccnt_q + PERW'(1);
        end

        // The hold decision taken at the pair start also governs the matching falling enable.
        hold_d      = cpu_start ? cpu_hold : hold_q;

        pix_p_d     = (pcnt_q == '0);
        pix_n_d     = (pcnt_q == PCW'(SYS_DIV / 2));
        cpu_p_d     = cpu_start && !cpu_hold;
        cpu_n_d     = (ccnt_q == (period >> 1)) && !hold_q;
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            pcnt_q      <= '0;
            pidx_q      <= '0;
            ccnt_q      <= '0;
            turbo_act_q <= '0;
            hold_q      <= 1'b0;
            pix_p_q     <= 1'b0;
            pix_n_q     <= 1'b0;
            cpu_p_q     <= 1'b0;
            cpu_n_q     <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            pidx_q      <= pidx_d;
            ccnt_q      <= ccnt_d;
            turbo_act_q <= turbo_act_d;
            hold_q      <= hold_d;
            pix_p_q     <= pix_p_d;
            pix_n_q     <= pix_n_d;
            cpu_p_q     <= cpu_p_d;
            cpu_n_q     <= cpu_n_d;
        end
    end

    assign ce_pix_p  = pix_p_q;
    assign ce_pix_n  = pix_n_q;
    assign ce_cpu_p  = cpu_p_q;
    assign ce_cpu_n  = cpu_n_q;
    assign turbo_act = turbo_act_q;

endmodule
